lsqueue_gen: RTL and testbench
==============================

// Module: lsqueue_gen
// PURPOSE
//  Parametrised load/store queue between the execution stage and the data port. Generalises the
//  RV32 queue to C_XLEN in {32,64}: full LB/LH/LW/LD/LBU/LHU/LWU formatting, lane alignment of
//  store data and load data, misalignment rejection, a bounded outstanding-transaction counter
//  and a flush of unissued requests. Loads write back to the register file in program order.
// PARAMETERS
//  C_XLEN          32  data/address width; only 32 or 64 legal (elaboration error otherwise)
//  C_FIFO_DEPTH_X  2   log2 depth of the request, response-control and response-data FIFOs
//  C_MAX_OUTST     4   max issued-but-unanswered transactions (1..2**C_FIFO_DEPTH_X)
// PORTS
//  clk_i            in   1       clock, all state on rising edge
//  resetb_i         in   1       asynchronous active-low reset
//  clk_en_i         in   1       state advances only when high
//  flush_i          in   1       discard all not-yet-issued requests
//  exs_lq_wr_i      in   1       enqueue load (exclusive with exs_sq_wr_i)
//  exs_sq_wr_i      in   1       enqueue store
//  exs_funct3_i     in   3       RISC-V funct3 (size [1:0], unsigned [2])
//  exs_hpl_i        in   2       privilege level of access
//  exs_regd_addr_i  in   5       load destination register
//  exs_regs2_data_i in   C_XLEN  store data (LSB-aligned)
//  exs_addr_i       in   C_XLEN  byte address
//  exs_full_o       out  1       request FIFO full
//  exs_empty_o      out  1       request FIFO, rsp-ctrl FIFO empty and outstanding count 0
//  exs_misalign_o   out  1       comb.: current enqueue attempt misaligned, rejected
//  lsq_reg_wr_o     out  1       register write-back strobe
//  lsq_reg_addr_o   out  5       write-back register
//  lsq_reg_data_o   out  C_XLEN  formatted load data
//  plic_int_laf_o / plic_int_saf_o  out 1  load / store access fault pulse
//  dreqready_i in 1; dreqvalid_o, dreqdvalid_o(=store) out 1; dreqsize_o out 2; dreqhpl_o out 2
//  dreqaddr_o, dreqdata_o out C_XLEN; drspready_o out 1; drspvalid_i, drsprerr_i, drspwerr_i in 1
//  drspdata_i in C_XLEN
// BEHAVIOUR
//  - Reset: all FIFOs empty, outstanding count 0; dreqvalid_o=0, lsq_reg_wr_o=0, exs_full_o=0,
//    exs_empty_o=1, fault pulses 0. Reset mid-transaction drops all state; late responses ignored
//    (drspready_o=0 while count==0).
//  - Enqueue when (lq|sq)&~exs_full_o&~misaligned&clk_en_i. Misaligned = addr[size-1:0]!=0;
//    size 3 with C_XLEN=32 is also illegal -> misalign. Enqueue while full is dropped (caller bug).
//  - Issue: dreqvalid_o = ~req_empty & ~ctrl_full & (count<C_MAX_OUTST). Transfer on
//    dreqvalid_o&dreqready_i; head pops; ctrl FIFO pushes {wr,regd,funct3,addr[2:0]}; count+1.
//  - Store data replicated to all lanes of its size (SB byte x N, SH half x N/2, SW word x N/4).
//  - Response accept: drspready_o = drspvalid_i & count!=0 & (ctrl head is store | ~data_full).
//    On accept count-1; store: ctrl pops immediately, saf pulses if drspwerr_i. Load: data FIFO
//    pushes (0 if drsprerr_i), laf pulses if drsprerr_i.
//  - Write-back: lsq_reg_wr_o = ~data_empty & ctrl head is load; pops both FIFOs same cycle.
//    Data = rdata >> (8*addr_off), then sign/zero extend per funct3; LD/64-bit raw.
//  - Issue and response in same cycle: count unchanged. Push/pop same cycle on a non-empty FIFO:
//    both occur, occupancy unchanged. Pointers wrap modulo 2**C_FIFO_DEPTH_X.
//  - flush_i (clk_en_i high): request FIFO emptied next cycle, overriding same-cycle enqueue; an
//    issue handshaking that cycle still completes; issued transactions drain normally.
// TESTING
//  1 C_XLEN=64: LB addr 0x1003, rsp 0x00000000_80000000 -> reg data 0xFFFFFFFF_FFFFFF80.
//  2 SH addr 0x12 data 0xBEEF -> dreqdata 0xBEEFBEEF_BEEFBEEF, dreqsize 1, dreqdvalid 1.
//  3 LW addr 0x2002 -> exs_misalign_o=1, nothing enqueued, exs_empty_o stays 1.
//  4 C_MAX_OUTST=2, 3 loads, dreqready_i=1, no rsp -> dreqvalid_o low after 2 issues; 1 rsp ->
//    3rd issues.
//  5 Load with drsprerr_i -> laf pulse 1 cycle, reg written with 0; store drspwerr_i -> saf only.
//  6 4 loads queued, dreqready_i=0, flush_i pulse -> exs_empty_o=1 next cycle, no requests issue.

Source files
------------

// File: rtl/lsqueue_gen.sv
// lsqueue_gen: load/store queue between the execution stage and the data port.
// Requests are buffered in a request FIFO, issued in order, and tracked in a
// response-control FIFO. Load data returns through a data FIFO and is written
// back in program order after lane extraction and sign/zero extension.
module lsqueue_gen #(
  parameter int C_XLEN         = 32,
  parameter int C_FIFO_DEPTH_X = 2,
  parameter int C_MAX_OUTST    = 4
) (
  input  logic              clk_i,
  input  logic              resetb_i,
  input  logic              clk_en_i,
  input  logic              flush_i,
  input  logic              exs_lq_wr_i,
  input  logic              exs_sq_wr_i,
  input  logic [2:0]        exs_funct3_i,
  input  logic [1:0]        exs_hpl_i,
  input  logic [4:0]        exs_regd_addr_i,
  input  logic [C_XLEN-1:0] exs_regs2_data_i,
  input  logic [C_XLEN-1:0] exs_addr_i,
  output logic              exs_full_o,
  output logic              exs_empty_o,
  output logic              exs_misalign_o,
  output logic              lsq_reg_wr_o,
  output logic [4:0]        lsq_reg_addr_o,
  output logic [C_XLEN-1:0] lsq_reg_data_o,
  output logic              plic_int_laf_o,
  output logic              plic_int_saf_o,
  input  logic              dreqready_i,
  output logic              dreqvalid_o,
  output logic              dreqdvalid_o,
  output logic [1:0]        dreqsize_o,
  output logic [1:0]        dreqhpl_o,
  output logic [C_XLEN-1:0] dreqaddr_o,
  output logic [C_XLEN-1:0] dreqdata_o,
  output logic              drspready_o,
  input  logic              drspvalid_i,
  input  logic              drsprerr_i,
  input  logic              drspwerr_i,
  input  logic [C_XLEN-1:0] drspdata_i
);

  localparam int DEPTH = 2 ** C_FIFO_DEPTH_X;

  typedef logic [C_XLEN-1:0]       xlen_t;
  typedef logic [C_FIFO_DEPTH_X:0] ptr_t;   // extra MSB distinguishes full from empty

  localparam ptr_t DEPTH_P     = ptr_t'(DEPTH);
  localparam ptr_t MAX_OUTST_P = ptr_t'(C_MAX_OUTST);

  typedef struct packed {
    logic       wr;
    logic [2:0] funct3;
    logic [1:0] hpl;
    logic [4:0] regd;
    xlen_t      data;
    xlen_t      addr;
  } req_t;

  typedef struct packed {
    logic       wr;
    logic [4:0] regd;
    logic [2:0] funct3;
    logic [2:0] off;
  } ctrl_t;

  // Reject illegal parameterisations at elaboration time.
  if (C_XLEN != 32 && C_XLEN != 64) begin : g_bad_xlen
    $error("lsqueue_gen: C_XLEN must be 32 or 64");
  end
  if (C_MAX_OUTST < 1 || C_MAX_OUTST > DEPTH) begin : g_bad_outst
    $error("lsqueue_gen: C_MAX_OUTST must be in 1..2**C_FIFO_DEPTH_X");
  end

  // ---------------------------------------------------------------- storage
  req_t  req_mem_q  [DEPTH];
  ctrl_t ctrl_mem_q [DEPTH];
  xlen_t data_mem_q [DEPTH];

  ptr_t req_wr_q, req_wr_d, req_rd_q, req_rd_d;
  ptr_t ctrl_wr_q, ctrl_wr_d, ctrl_rsp_q, ctrl_rsp_d, ctrl_rd_q, ctrl_rd_d;
  ptr_t data_wr_q, data_wr_d, data_rd_q, data_rd_d;
  logic laf_q, laf_d, saf_q, saf_d;

  // ---------------------------------------------------------------- status
  logic req_empty, req_full, ctrl_empty, ctrl_full, data_empty, data_full;
  ptr_t outst;

  assign req_empty  = (req_wr_q == req_rd_q);
  assign req_full   = ((req_wr_q - req_rd_q) == DEPTH_P);
  assign ctrl_empty = (ctrl_wr_q == ctrl_rd_q);
  assign ctrl_full  = ((ctrl_wr_q - ctrl_rd_q) == DEPTH_P);
  assign data_empty = (data_wr_q == data_rd_q);
  assign data_full  = ((data_wr_q - data_rd_q) == DEPTH_P);
  // Issued entries between the response pointer and the write pointer are unanswered.
  assign outst      = ctrl_wr_q - ctrl_rsp_q;

  // ---------------------------------------------------------------- enqueue
  logic  misal;
  logic  req_push;
  xlen_t st_data_rep;
  req_t  req_new;

  // Alignment check on the incoming access; doublewords do not exist on a 32-bit port.
  always_comb begin
    misal = 1'b0;
    unique case (exs_funct3_i[1:0])
      2'd0:    misal = 1'b0;
      2'd1:    misal = exs_addr_i[0];
      2'd2:    misal = |exs_addr_i[1:0];
      default: misal = (C_XLEN == 32) ? 1'b1 : |exs_addr_i[2:0];
    endcase
  end

  assign exs_misalign_o = (exs_lq_wr_i | exs_sq_wr_i) & misal;
  assign req_push       = (exs_lq_wr_i | exs_sq_wr_i) & ~req_full & ~misal & clk_en_i;

  // Replicate store data across every lane of its size so the slave picks any lane.
  for (genvar gi = 0; gi < C_XLEN / 8; gi++) begin : g_lane
    assign st_data_rep[8*gi +: 8] =
        (exs_funct3_i[1:0] == 2'd0) ? exs_regs2_data_i[7:0] :
        (exs_funct3_i[1:0] == 2'd1) ? exs_regs2_data_i[8*(gi%2) +: 8] :
        (exs_funct3_i[1:0] == 2'd2) ? exs_regs2_data_i[8*(gi%4) +: 8] :
                                      exs_regs2_data_i[8*gi +: 8];
  end

  assign req_new = '{wr: exs_sq_wr_i, funct3: exs_funct3_i, hpl: exs_hpl_i,
                     regd: exs_regd_addr_i, data: st_data_rep, addr: exs_addr_i};

  // ---------------------------------------------------------------- issue
  req_t  req_head;
  logic  issue;
  ctrl_t ctrl_new;

  assign req_head     = req_mem_q[req_rd_q[C_FIFO_DEPTH_X-1:0]];
  assign dreqvalid_o  = clk_en_i & ~req_empty & ~ctrl_full & (outst < MAX_OUTST_P);
  assign issue        = dreqvalid_o & dreqready_i;
  assign dreqdvalid_o = dreqvalid_o & req_head.wr;
  assign dreqsize_o   = req_head.funct3[1:0];
  assign dreqhpl_o    = req_head.hpl;
  assign dreqaddr_o   = req_head.addr;
  assign dreqdata_o   = req_head.data;
  assign ctrl_new     = '{wr: req_head.wr, regd: req_head.regd,
                          funct3: req_head.funct3, off: req_head.addr[2:0]};

  // ---------------------------------------------------------------- response
  logic  rsp_is_store, rsp_acc, data_push;
  xlen_t data_new;

  assign rsp_is_store = ctrl_mem_q[ctrl_rsp_q[C_FIFO_DEPTH_X-1:0]].wr;
  assign drspready_o  = clk_en_i & drspvalid_i & (outst != '0) & (rsp_is_store | ~data_full);
  assign rsp_acc      = drspready_o;
  assign data_push    = rsp_acc & ~rsp_is_store;
  assign data_new     = drsprerr_i ? '0 : drspdata_i;

  // ---------------------------------------------------------------- write-back
  ctrl_t ctrl_head;
  logic  wb, st_pop, ctrl_pop;
  logic  [2:0] wb_off;
  xlen_t wb_shift;

  assign ctrl_head = ctrl_mem_q[ctrl_rd_q[C_FIFO_DEPTH_X-1:0]];
  assign wb        = clk_en_i & ~data_empty & ~ctrl_empty & ~ctrl_head.wr;
  // An answered store leaves at once; rd==rsp with an accept means the head is being answered now.
  assign st_pop    = clk_en_i & ~ctrl_empty & ctrl_head.wr &
                     ((ctrl_rd_q != ctrl_rsp_q) | rsp_acc);
  assign ctrl_pop  = wb | st_pop;
  assign wb_off    = (C_XLEN == 64) ? ctrl_head.off : {1'b0, ctrl_head.off[1:0]};
  assign wb_shift  = data_mem_q[data_rd_q[C_FIFO_DEPTH_X-1:0]] >> {wb_off, 3'b000};

  // Extract the addressed lane and extend it according to funct3.
  always_comb begin
    lsq_reg_data_o = wb_shift;
    unique case (ctrl_head.funct3)
      3'b000:  lsq_reg_data_o = xlen_t'($signed(wb_shift[7:0]));
      3'b001:  lsq_reg_data_o = xlen_t'($signed(wb_shift[15:0]));
      3'b010:  lsq_reg_data_o = xlen_t'($signed(wb_shift[31:0]));
      3'b100:  lsq_reg_data_o = xlen_t'(wb_shift[7:0]);
      3'b101:  lsq_reg_data_o = xlen_t'(wb_shift[15:0]);
      3'b110:  lsq_reg_data_o = xlen_t'(wb_shift[31:0]);
      default: lsq_reg_data_o = wb_shift;
    endcase
  end

  assign lsq_reg_wr_o   = wb;
  assign lsq_reg_addr_o = ctrl_head.regd;

  // ---------------------------------------------------------------- next state
  // Pointer and fault-pulse next state; a flush empties the request FIFO after any same-cycle issue.
  always_comb begin
    req_wr_d   = req_wr_q + ptr_t'(req_push);
    req_rd_d   = req_rd_q + ptr_t'(issue);
    ctrl_wr_d  = ctrl_wr_q + ptr_t'(issue);
    ctrl_rsp_d = ctrl_rsp_q + ptr_t'(rsp_acc);
    ctrl_rd_d  = ctrl_rd_q + ptr_t'(ctrl_pop);
    data_wr_d  = data_wr_q + ptr_t'(data_push);
    data_rd_d  = data_rd_q + ptr_t'(wb);
    laf_d      = rsp_acc & ~rsp_is_store & drsprerr_i;
    saf_d      = rsp_acc & rsp_is_store & drspwerr_i;
    if (flush_i && clk_en_i) begin
      req_wr_d = req_rd_d;
    end
  end

  // Control registers with asynchronous reset; reset drops every in-flight transaction.
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      req_wr_q   <= '0;
      req_rd_q   <= '0;
      ctrl_wr_q  <= '0;
      ctrl_rsp_q <= '0;
      ctrl_rd_q  <= '0;
      data_wr_q  <= '0;
      data_rd_q  <= '0;
      laf_q      <= 1'b0;
      saf_q      <= 1'b0;
    end else begin
      req_wr_q   <= req_wr_d;
      req_rd_q   <= req_rd_d;
      ctrl_wr_q  <= ctrl_wr_d;
      ctrl_rsp_q <= ctrl_rsp_d;
      ctrl_rd_q  <= ctrl_rd_d;
      data_wr_q  <= data_wr_d;
      data_rd_q  <= data_rd_d;
      laf_q      <= laf_d;
      saf_q      <= saf_d;
    end
  end

  // FIFO storage arrays; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk_i) begin
    if (req_push)  req_mem_q[req_wr_q[C_FIFO_DEPTH_X-1:0]]   <= req_new;
    if (issue)     ctrl_mem_q[ctrl_wr_q[C_FIFO_DEPTH_X-1:0]] <= ctrl_new;
    if (data_push) data_mem_q[data_wr_q[C_FIFO_DEPTH_X-1:0]] <= data_new;
  end

  assign exs_full_o     = req_full;
  assign exs_empty_o    = req_empty & ctrl_empty & (outst == '0);
  assign plic_int_laf_o = laf_q;
  assign plic_int_saf_o = saf_q;

endmodule

// File: tb/tb_lsqueue_gen.sv
// Directed testbench for lsqueue_gen (64-bit, depth 4, two outstanding).
module tb_lsqueue_gen;

  logic        clk = 1'b0;
  logic        resetb, clk_en, flush, lq_wr, sq_wr;
  logic [2:0]  funct3;
  logic [1:0]  hpl;
  logic [4:0]  regd;
  logic [63:0] regs2, addr;
  logic        full, empty, misalign, reg_wr;
  logic [4:0]  reg_addr;
  logic [63:0] reg_data;
  logic        laf, saf, dreqready, dreqvalid, dreqdvalid;
  logic [1:0]  dreqsize, dreqhpl;
  logic [63:0] dreqaddr, dreqdata;
  logic        drspready, drspvalid, drsprerr, drspwerr;
  logic [63:0] drspdata;

  int tests = 0;
  int fails = 0;

  lsqueue_gen #(.C_XLEN(64), .C_FIFO_DEPTH_X(2), .C_MAX_OUTST(2)) dut (
    .clk_i(clk), .resetb_i(resetb), .clk_en_i(clk_en), .flush_i(flush),
    .exs_lq_wr_i(lq_wr), .exs_sq_wr_i(sq_wr), .exs_funct3_i(funct3), .exs_hpl_i(hpl),
    .exs_regd_addr_i(regd), .exs_regs2_data_i(regs2), .exs_addr_i(addr),
    .exs_full_o(full), .exs_empty_o(empty), .exs_misalign_o(misalign),
    .lsq_reg_wr_o(reg_wr), .lsq_reg_addr_o(reg_addr), .lsq_reg_data_o(reg_data),
    .plic_int_laf_o(laf), .plic_int_saf_o(saf),
    .dreqready_i(dreqready), .dreqvalid_o(dreqvalid), .dreqdvalid_o(dreqdvalid),
    .dreqsize_o(dreqsize), .dreqhpl_o(dreqhpl), .dreqaddr_o(dreqaddr), .dreqdata_o(dreqdata),
    .drspready_o(drspready), .drspvalid_i(drspvalid), .drsprerr_i(drsprerr),
    .drspwerr_i(drspwerr), .drspdata_i(drspdata)
  );

  always #5 clk = ~clk;

  // Present one enqueue at a falling edge and remove it at the next falling edge.
  task automatic enq(input logic st, input logic [2:0] f3, input logic [4:0] rd,
                     input logic [63:0] a, input logic [63:0] d);
    lq_wr = ~st; sq_wr = st; funct3 = f3; regd = rd; addr = a; regs2 = d;
    @(negedge clk);
    lq_wr = 1'b0; sq_wr = 1'b0;
    $display("[TB] enq %s f3=%0d rd=%0d addr=%h", st ? "store" : "load", f3, rd, a);
  endtask

  task automatic test_reset;
    resetb = 1'b0;
    repeat (3) @(negedge clk);
    resetb = 1'b1;
    drspvalid = 1'b1;
    #1;
    tests++; if (dreqvalid !== 1'b0) begin fails++; $display("FAIL reset_dreqvalid got %b want 0", dreqvalid); end
    tests++; if (reg_wr !== 1'b0) begin fails++; $display("FAIL reset_reg_wr got %b want 0", reg_wr); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full got %b want 0", full); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b want 1", empty); end
    tests++; if ({laf, saf} !== 2'b00) begin fails++; $display("FAIL reset_faults got %b want 00", {laf, saf}); end
    tests++; if (drspready !== 1'b0) begin fails++; $display("FAIL reset_drspready got %b want 0", drspready); end
    drspvalid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lb_sext;
    enq(1'b0, 3'b000, 5'd5, 64'h1003, 64'h0);
    tests++; if (dreqvalid !== 1'b1) begin fails++; $display("FAIL lb_dreqvalid got %b want 1", dreqvalid); end
    tests++; if (dreqaddr !== 64'h1003) begin fails++; $display("FAIL lb_dreqaddr got %h want 1003", dreqaddr); end
    tests++; if ({dreqsize, dreqdvalid} !== 3'b000) begin fails++; $display("FAIL lb_size_dvalid got %b want 000", {dreqsize, dreqdvalid}); end
    @(negedge clk);
    drspvalid = 1'b1; drspdata = 64'h00000000_80000000;
    #1;
    tests++; if (drspready !== 1'b1) begin fails++; $display("FAIL lb_drspready got %b want 1", drspready); end
    @(negedge clk);
    drspvalid = 1'b0;
    tests++; if (reg_wr !== 1'b1) begin fails++; $display("FAIL lb_reg_wr got %b want 1", reg_wr); end
    tests++; if (reg_addr !== 5'd5) begin fails++; $display("FAIL lb_reg_addr got %0d want 5", reg_addr); end
    tests++; if (reg_data !== 64'hFFFFFFFF_FFFFFF80) begin fails++; $display("FAIL lb_reg_data got %h want ffffffffffffff80", reg_data); end
    @(negedge clk);
    tests++; if (reg_wr !== 1'b0) begin fails++; $display("FAIL lb_reg_wr_done got %b want 0", reg_wr); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL lb_empty got %b want 1", empty); end
    $display("[TB] LB sign-extend done");
  endtask

  task automatic test_sh_replicate;
    enq(1'b1, 3'b001, 5'd0, 64'h12, 64'hBEEF);
    tests++; if (dreqdata !== 64'hBEEFBEEF_BEEFBEEF) begin fails++; $display("FAIL sh_dreqdata got %h want beefbeefbeefbeef", dreqdata); end
    tests++; if (dreqsize !== 2'd1) begin fails++; $display("FAIL sh_dreqsize got %0d want 1", dreqsize); end
    tests++; if ({dreqvalid, dreqdvalid} !== 2'b11) begin fails++; $display("FAIL sh_valid_dvalid got %b want 11", {dreqvalid, dreqdvalid}); end
    @(negedge clk);
    drspvalid = 1'b1; drspdata = 64'h0;
    #1;
    tests++; if (drspready !== 1'b1) begin fails++; $display("FAIL sh_drspready got %b want 1", drspready); end
    @(negedge clk);
    drspvalid = 1'b0;
    tests++; if ({saf, reg_wr} !== 2'b00) begin fails++; $display("FAIL sh_saf_regwr got %b want 00", {saf, reg_wr}); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL sh_empty got %b want 1", empty); end
    $display("[TB] SH replicate done");
  endtask

  task automatic test_misalign;
    lq_wr = 1'b1; funct3 = 3'b010; addr = 64'h2002; regd = 5'd9;
    #1;
    tests++; if (misalign !== 1'b1) begin fails++; $display("FAIL mis_flag got %b want 1", misalign); end
    @(negedge clk);
    lq_wr = 1'b0;
    #1;
    tests++; if (misalign !== 1'b0) begin fails++; $display("FAIL mis_idle got %b want 0", misalign); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL mis_empty got %b want 1", empty); end
    tests++; if (dreqvalid !== 1'b0) begin fails++; $display("FAIL mis_dreqvalid got %b want 0", dreqvalid); end
    @(negedge clk);
    $display("[TB] LW misalign done");
  endtask

  task automatic test_outstanding;
    enq(1'b0, 3'b010, 5'd1, 64'h100, 64'h0);
    enq(1'b0, 3'b010, 5'd2, 64'h104, 64'h0);
    enq(1'b0, 3'b110, 5'd3, 64'h108, 64'h0);
    tests++; if (dreqvalid !== 1'b0) begin fails++; $display("FAIL outst_block got %b want 0", dreqvalid); end
    @(negedge clk);
    tests++; if (dreqvalid !== 1'b0) begin fails++; $display("FAIL outst_block2 got %b want 0", dreqvalid); end
    drspvalid = 1'b1; drspdata = 64'h11112222_33334444;
    #1;
    tests++; if (drspready !== 1'b1) begin fails++; $display("FAIL outst_rspA got %b want 1", drspready); end
    @(negedge clk);
    drspvalid = 1'b0;
    tests++; if ({dreqvalid, dreqaddr} !== {1'b1, 64'h108}) begin fails++; $display("FAIL outst_third got %b/%h want 1/108", dreqvalid, dreqaddr); end
    tests++; if ({reg_wr, reg_addr} !== {1'b1, 5'd1}) begin fails++; $display("FAIL outst_wbA got %b/%0d want 1/1", reg_wr, reg_addr); end
    tests++; if (reg_data !== 64'h00000000_33334444) begin fails++; $display("FAIL outst_dataA got %h want 0000000033334444", reg_data); end
    @(negedge clk);
    drspvalid = 1'b1; drspdata = 64'h80000000_12345678;
    #1;
    tests++; if (drspready !== 1'b1) begin fails++; $display("FAIL outst_rspB got %b want 1", drspready); end
    @(negedge clk);
    tests++; if ({reg_wr, reg_addr} !== {1'b1, 5'd2}) begin fails++; $display("FAIL outst_wbB got %b/%0d want 1/2", reg_wr, reg_addr); end
    tests++; if (reg_data !== 64'hFFFFFFFF_80000000) begin fails++; $display("FAIL outst_dataB got %h want ffffffff80000000", reg_data); end
    drspdata = 64'hDEADBEEF_80000001;
    @(negedge clk);
    drspvalid = 1'b0;
    tests++; if ({reg_wr, reg_addr} !== {1'b1, 5'd3}) begin fails++; $display("FAIL outst_wbC got %b/%0d want 1/3", reg_wr, reg_addr); end
    tests++; if (reg_data !== 64'h00000000_80000001) begin fails++; $display("FAIL outst_dataC got %h want 0000000080000001", reg_data); end
    @(negedge clk);
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL outst_empty got %b want 1", empty); end
    $display("[TB] outstanding limit done");
  endtask

  task automatic test_faults;
    enq(1'b0, 3'b011, 5'd7, 64'h200, 64'h0);
    @(negedge clk);
    drspvalid = 1'b1; drsprerr = 1'b1; drspdata = 64'hFFFFFFFF_FFFFFFFF;
    @(negedge clk);
    drspvalid = 1'b0; drsprerr = 1'b0;
    tests++; if ({laf, saf} !== 2'b10) begin fails++; $display("FAIL laf_pulse got %b want 10", {laf, saf}); end
    tests++; if ({reg_wr, reg_addr, reg_data} !== {1'b1, 5'd7, 64'h0}) begin fails++; $display("FAIL laf_wb got %b/%0d/%h want 1/7/0", reg_wr, reg_addr, reg_data); end
    @(negedge clk);
    tests++; if (laf !== 1'b0) begin fails++; $display("FAIL laf_end got %b want 0", laf); end
    enq(1'b1, 3'b010, 5'd0, 64'h300, 64'h1234);
    @(negedge clk);
    drspvalid = 1'b1; drspwerr = 1'b1;
    @(negedge clk);
    drspvalid = 1'b0; drspwerr = 1'b0;
    tests++; if ({laf, saf, reg_wr} !== 3'b010) begin fails++; $display("FAIL saf_pulse got %b want 010", {laf, saf, reg_wr}); end
    @(negedge clk);
    tests++; if ({saf, empty} !== 2'b01) begin fails++; $display("FAIL saf_end got %b want 01", {saf, empty}); end
    $display("[TB] access faults done");
  endtask

  task automatic test_flush;
    dreqready = 1'b0;
    for (int i = 0; i < 4; i++) enq(1'b0, 3'b010, 5'(10 + i), 64'h400 + 64'(4 * i), 64'h0);
    tests++; if ({full, empty, dreqvalid} !== 3'b101) begin fails++; $display("FAIL flush_pre got %b want 101", {full, empty, dreqvalid}); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    tests++; if ({full, empty, dreqvalid} !== 3'b010) begin fails++; $display("FAIL flush_post got %b want 010", {full, empty, dreqvalid}); end
    dreqready = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if ({dreqvalid, empty} !== 2'b01) begin fails++; $display("FAIL flush_drain got %b want 01", {dreqvalid, empty}); end
    $display("[TB] flush done");
  endtask

  task automatic test_reset_mid;
    enq(1'b0, 3'b010, 5'd4, 64'h500, 64'h0);
    @(negedge clk);
    resetb = 1'b0;
    drspvalid = 1'b1; drspdata = 64'h55;
    #1;
    tests++; if (drspready !== 1'b0) begin fails++; $display("FAIL rstmid_in got %b want 0", drspready); end
    @(negedge clk);
    resetb = 1'b1;
    #1;
    tests++; if ({drspready, empty, reg_wr} !== 3'b010) begin fails++; $display("FAIL rstmid_out got %b want 010", {drspready, empty, reg_wr}); end
    drspvalid = 1'b0;
    @(negedge clk);
    $display("[TB] mid-transaction reset done");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetb = 1'b0; clk_en = 1'b1; flush = 1'b0; lq_wr = 1'b0; sq_wr = 1'b0;
    funct3 = 3'b0; hpl = 2'b11; regd = 5'd0; regs2 = 64'h0; addr = 64'h0;
    dreqready = 1'b1; drspvalid = 1'b0; drsprerr = 1'b0; drspwerr = 1'b0; drspdata = 64'h0;
    @(negedge clk);
    test_reset;
    test_lb_sext;
    test_sh_replicate;
    test_misalign;
    test_outstanding;
    test_faults;
    test_flush;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
